// File: rtl/dc_fetch_queue.sv
// dc_fetch_queue: decode-side receiver for the fetch handshake.
//   Accepts pc/inst/jump transfers from fetch (IF_valid/DC_ready) into a circular
//   FIFO, predecodes each accepted instruction to catch BPU errors that decode can
//   resolve (unpredicted JAL, taken prediction on a non-control instruction), and
//   raises a one-cycle registered redirect to fetch. The head is offered to issue
//   through DC_out_valid/IS_ready; a backend mispredict flushes the queue.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   IF_valid, IF_out_*   fetch transfer (pc, inst, predicted jump)
//   DC_ready             queue not full
//   mispredict           backend flush
//   stall, IS_ready      issue-side freeze and accept
//   DC_out_*             head entry (valid, pc, inst, corrected jump)
//   DC_mispredict        redirect pulse to fetch, target in DC_redirect_pc
module dc_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_valid,
  input  logic [31:0] IF_out_pc,
  input  logic [31:0] IF_out_inst,
  input  logic        IF_out_jump,
  output logic        DC_ready,
  input  logic        mispredict,
  input  logic        stall,
  input  logic        IS_ready,
  output logic        DC_out_valid,
  output logic [31:0] DC_out_pc,
  output logic [31:0] DC_out_inst,
  output logic        DC_out_jump,
  output logic        DC_mispredict,
  output logic [31:0] DC_redirect_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic        jump_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;

  logic        full;
  logic        accept;
  logic        deq;
  logic [6:0]  opcode;
  logic        is_jal;
  logic        is_ctrl;
  logic        enq_jump;
  logic        need_redirect;
  logic [31:0] jal_imm;
  logic [31:0] target;

  assign full         = (count_q == CntW'(DEPTH));
  assign DC_ready     = !full;
  assign DC_out_valid = (count_q != '0);
  assign DC_out_pc    = pc_mem_q[rd_ptr_q];
  assign DC_out_inst  = inst_mem_q[rd_ptr_q];
  assign DC_out_jump  = jump_mem_q[rd_ptr_q];
  assign DC_mispredict  = redirect_q;
  assign DC_redirect_pc = redirect_pc_q;

  // A handshake during a flush or during the redirect pulse is consumed but dropped.
  assign accept = IF_valid & DC_ready & !mispredict & !redirect_q;
  assign deq    = DC_out_valid & IS_ready & !stall;

  assign opcode  = IF_out_inst[6:0];
  assign is_jal  = (opcode == OpJal);
  assign is_ctrl = (opcode == OpBranch) | is_jal | (opcode == OpJalr);
  assign jal_imm = {{11{IF_out_inst[31]}}, IF_out_inst[31], IF_out_inst[19:12],
                    IF_out_inst[20], IF_out_inst[30:21], 1'b0};

  always_comb begin
    enq_jump      = IF_out_jump;
    need_redirect = 1'b0;
    target        = IF_out_pc + 32'd4;
    if (is_jal && !IF_out_jump) begin
      enq_jump      = 1'b1;
      need_redirect = 1'b1;
      target        = IF_out_pc + jal_imm;
    end else if (IF_out_jump && !is_ctrl) begin
      enq_jump      = 1'b0;
      need_redirect = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    redirect_d    = accept & need_redirect;
    redirect_pc_d = redirect_pc_q;
    if (accept && need_redirect) begin
      redirect_pc_d = target;
    end
    if (mispredict) begin
      // Same-cycle dequeue still completes at issue; the queue just empties.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq)    rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(accept) - CntW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        jump_mem_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      if (accept) begin
        pc_mem_q[wr_ptr_q]   <= IF_out_pc;
        inst_mem_q[wr_ptr_q] <= IF_out_inst;
        jump_mem_q[wr_ptr_q] <= enq_jump;
      end
    end
  end

endmodule

// File: tb/tb_dc_fetch_queue.sv
module tb_dc_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_valid;
  logic [31:0] IF_out_pc;
  logic [31:0] IF_out_inst;
  logic        IF_out_jump;
  logic        DC_ready;
  logic        mispredict;
  logic        stall;
  logic        IS_ready;
  logic        DC_out_valid;
  logic [31:0] DC_out_pc;
  logic [31:0] DC_out_inst;
  logic        DC_out_jump;
  logic        DC_mispredict;
  logic [31:0] DC_redirect_pc;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Jal  = 32'h0100_006F;  // jal x0, +16
  localparam logic [31:0] Beq  = 32'h0000_0063;
  localparam logic [31:0] Jalr = 32'h0000_8067;

  always #5 clk = ~clk;

  dc_fetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_valid       (IF_valid),
    .IF_out_pc      (IF_out_pc),
    .IF_out_inst    (IF_out_inst),
    .IF_out_jump    (IF_out_jump),
    .DC_ready       (DC_ready),
    .mispredict     (mispredict),
    .stall          (stall),
    .IS_ready       (IS_ready),
    .DC_out_valid   (DC_out_valid),
    .DC_out_pc      (DC_out_pc),
    .DC_out_inst    (DC_out_inst),
    .DC_out_jump    (DC_out_jump),
    .DC_mispredict  (DC_mispredict),
    .DC_redirect_pc (DC_redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic j);
    IF_valid    = v;
    IF_out_pc   = pc;
    IF_out_inst = inst;
    IF_out_jump = j;
  endtask

  logic [31:0] mq[$];
  int          mcount;
  int          sent;
  int          got;
  logic        acc;
  logic        dq;

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    mispredict = 1'b0;
    stall      = 1'b0;
    IS_ready   = 1'b0;
    #1;
    chk("rst_ready", 32'(DC_ready), 32'd1);
    chk("rst_valid", 32'(DC_out_valid), 32'd0);
    chk("rst_pc", DC_out_pc, 32'h0);
    chk("rst_inst", DC_out_inst, 32'h0);
    chk("rst_jump", 32'(DC_out_jump), 32'd0);
    chk("rst_misp", 32'(DC_mispredict), 32'd0);
    chk("rst_redir", DC_redirect_pc, 32'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // Reset with traffic: asynchronous clear between edges.
    drive(1'b1, 32'h10, Nop, 1'b0); step();
    drive(1'b1, 32'h14, Nop, 1'b0); step();
    drive(1'b1, 32'h18, Nop, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("traffic_valid", 32'(DC_out_valid), 32'd1);
    chk("traffic_head", DC_out_pc, 32'h10);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(DC_out_valid), 32'd0);
    chk("async_rst_ready", 32'(DC_ready), 32'd1);
    chk("async_rst_pc", DC_out_pc, 32'h0);
    rst = 1'b1;
    step();
    chk("post_rst_valid", 32'(DC_out_valid), 32'd0);

    // Fill to full with issue blocked.
    drive(1'b1, 32'h0, Nop, 1'b0); step();
    drive(1'b1, 32'h4, Nop, 1'b0); step();
    drive(1'b1, 32'h8, Nop, 1'b0); step();
    chk("fill3_ready", 32'(DC_ready), 32'd1);
    drive(1'b1, 32'hC, Nop, 1'b0); step();
    chk("full_ready", 32'(DC_ready), 32'd0);
    chk("full_head", DC_out_pc, 32'h0);
    // Offer one more while full and dequeuing: must not be taken.
    drive(1'b1, 32'h20, Nop, 1'b0);
    IS_ready = 1'b1;
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("deq1_head", DC_out_pc, 32'h4);
    chk("deq1_ready", 32'(DC_ready), 32'd1);
    step();
    chk("deq2_head", DC_out_pc, 32'h8);
    step();
    chk("deq3_head", DC_out_pc, 32'hC);
    step();
    chk("drain_valid", 32'(DC_out_valid), 32'd0);
    IS_ready = 1'b0;

    // Unpredicted JAL.
    drive(1'b1, 32'h100, Jal, 1'b0); step();
    chk("jal_misp", 32'(DC_mispredict), 32'd1);
    chk("jal_target", DC_redirect_pc, 32'h110);
    chk("jal_head_pc", DC_out_pc, 32'h100);
    chk("jal_head_jump", 32'(DC_out_jump), 32'd1);
    drive(1'b1, 32'h104, Nop, 1'b0); step();
    chk("jal_pulse_end", 32'(DC_mispredict), 32'd0);
    drive(1'b1, 32'h110, Nop, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    IS_ready = 1'b1;
    chk("jal_out0", DC_out_pc, 32'h100);
    step();
    chk("jal_out1", DC_out_pc, 32'h110);
    step();
    chk("jal_drain", 32'(DC_out_valid), 32'd0);
    IS_ready = 1'b0;

    // False taken on a nop; branch and jalr predictions left alone.
    drive(1'b1, 32'h200, Nop, 1'b1); step();
    chk("ft_misp", 32'(DC_mispredict), 32'd1);
    chk("ft_target", DC_redirect_pc, 32'h204);
    chk("ft_head_jump", 32'(DC_out_jump), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0); step();
    drive(1'b1, 32'h204, Beq, 1'b1); step();
    chk("beq_no_misp", 32'(DC_mispredict), 32'd0);
    drive(1'b1, 32'h208, Jalr, 1'b1); step();
    chk("jalr_no_misp", 32'(DC_mispredict), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    IS_ready = 1'b1;
    stall    = 1'b1;
    step();
    chk("stall_hold", DC_out_pc, 32'h200);
    chk("stall_ready", 32'(DC_ready), 32'd1);
    stall = 1'b0;
    step();
    chk("beq_head", DC_out_pc, 32'h204);
    chk("beq_jump", 32'(DC_out_jump), 32'd1);
    step();
    chk("jalr_head", DC_out_pc, 32'h208);
    chk("jalr_jump", 32'(DC_out_jump), 32'd1);
    step();
    chk("ft_drain", 32'(DC_out_valid), 32'd0);
    IS_ready = 1'b0;

    // Flush racing a JAL mispredict and a dequeue.
    drive(1'b1, 32'h300, Nop, 1'b0); step();
    drive(1'b1, 32'h304, Nop, 1'b0); step();
    drive(1'b1, 32'h308, Jal, 1'b0);
    IS_ready   = 1'b1;
    mispredict = 1'b1;
    chk("flush_head", DC_out_pc, 32'h300);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    mispredict = 1'b0;
    chk("flush_valid", 32'(DC_out_valid), 32'd0);
    chk("flush_misp", 32'(DC_mispredict), 32'd0);
    chk("flush_ready", 32'(DC_ready), 32'd1);
    step();
    chk("flush_still_empty", 32'(DC_out_valid), 32'd0);

    // Pointer wrap: 11 entries, issue toggling.
    mcount = 0;
    sent   = 0;
    got    = 0;
    for (int cyc = 0; cyc < 100 && got < 11; cyc++) begin
      drive(sent < 11, 32'h400 + 32'(sent * 4), Nop, 1'b0);
      IS_ready = ((cyc % 2) == 1);
      #1;
      chk("wrap_ready", 32'(DC_ready), 32'(mcount < 4));
      chk("wrap_valid", 32'(DC_out_valid), 32'(mcount > 0));
      acc = IF_valid && (mcount < 4);
      dq  = IS_ready && (mcount > 0);
      if (dq) begin
        chk("wrap_order", DC_out_pc, mq[0]);
        void'(mq.pop_front());
        mcount--;
        got++;
      end
      if (acc) begin
        mq.push_back(IF_out_pc);
        mcount++;
        sent++;
      end
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    IS_ready = 1'b0;
    chk("wrap_count", 32'(got), 32'd11);
    chk("wrap_empty", 32'(DC_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
